// File: rtl/macguffin_frame_ctrl.sv
// rtl/macguffin_frame_ctrl.sv - UART frame controller: key load and 64-bit block exchange with a cipher core
// Optional receive idle-gap timeout: define MACGUFFIN_FRAME_CTRL_TIMEOUT_EN
module macguffin_frame_ctrl #(
  parameter logic [127:0] INIT_KEY       = 128'h1748a65f73b56f5eafecc84639475860,
  parameter int unsigned  TIMEOUT_CYCLES = 868_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [7:0]    m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [63:0]   c_m_axis_tdata,
  output logic          c_m_axis_tvalid,
  input  logic          c_m_axis_tready,
  input  logic [63:0]   c_s_axis_tdata,
  input  logic          c_s_axis_tvalid,
  output logic          c_s_axis_tready,
  output logic [127:0]  key,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE, RX_KEY, RX_BLK, CIPH_REQ, CIPH_WAIT, TX_DATA, TX_ACK, TX_NAK
  } state_t;

  state_t         state_q, state_d;
  logic [63:0]    blk_q, blk_d;
  logic [127:0]   stage_q, stage_d;
  logic [127:0]   key_q, key_d;
  logic           commit_q, commit_d;
  logic [63:0]    res_q, res_d;
  logic [2:0]     byte_cnt_q, byte_cnt_d;
  logic [3:0]     key_cnt_q, key_cnt_d;
  logic           rdy_en_q;
  logic           s_fire;

`ifdef MACGUFFIN_FRAME_CTRL_TIMEOUT_EN
  localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             gap_expired;
  assign gap_expired = (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));
`endif

  // rdy_en_q keeps the input closed until the first edge after reset release
  assign s_axis_tready   = rdy_en_q && (state_q == IDLE || state_q == RX_KEY || state_q == RX_BLK);
  assign s_fire          = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid   = (state_q == TX_DATA) || (state_q == TX_ACK) || (state_q == TX_NAK);
  assign c_m_axis_tvalid = (state_q == CIPH_REQ);
  assign c_m_axis_tdata  = blk_q;
  assign c_s_axis_tready = (state_q == CIPH_WAIT);
  assign key             = key_q;
  assign busy            = (state_q != IDLE);

  // Response byte: cipher result MSB first, or the single ACK/NAK code
  always_comb begin
    m_axis_tdata = 8'h00;
    case (state_q)
      TX_DATA: m_axis_tdata = res_q[63:56];
      TX_ACK:  m_axis_tdata = 8'h06;
      TX_NAK:  m_axis_tdata = 8'h15;
      default: m_axis_tdata = 8'h00;
    endcase
  end

  // Frame sequencing: command decode, byte collection, cipher handoff, response
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    stage_d    = stage_q;
    key_d      = key_q;
    commit_d   = 1'b0;
    res_d      = res_q;
    byte_cnt_d = byte_cnt_q;
    key_cnt_d  = key_cnt_q;
`ifdef MACGUFFIN_FRAME_CTRL_TIMEOUT_EN
    gap_d      = gap_q;
`endif
    // Staged key is committed whole, one cycle after its last byte
    if (commit_q) key_d = stage_q;

    unique case (state_q)
      IDLE: begin
        if (s_fire) begin
          byte_cnt_d = '0;
          key_cnt_d  = '0;
`ifdef MACGUFFIN_FRAME_CTRL_TIMEOUT_EN
          gap_d      = '0;
`endif
          if (s_axis_tdata == 8'h45)      state_d = RX_BLK;
          else if (s_axis_tdata == 8'h4B) state_d = RX_KEY;
          else                            state_d = TX_NAK;
        end
      end
      RX_BLK: begin
        if (s_fire) begin
          blk_d = {blk_q[55:0], s_axis_tdata};
`ifdef MACGUFFIN_FRAME_CTRL_TIMEOUT_EN
          gap_d = '0;
`endif
          if (byte_cnt_q == 3'd7) begin
            byte_cnt_d = '0;
            state_d    = CIPH_REQ;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
`ifdef MACGUFFIN_FRAME_CTRL_TIMEOUT_EN
        else if (gap_expired) begin
          gap_d   = '0;
          state_d = TX_NAK;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
`endif
      end
      RX_KEY: begin
        if (s_fire) begin
          stage_d = {stage_q[119:0], s_axis_tdata};
`ifdef MACGUFFIN_FRAME_CTRL_TIMEOUT_EN
          gap_d   = '0;
`endif
          if (key_cnt_q == 4'd15) begin
            key_cnt_d = '0;
            commit_d  = 1'b1;
            state_d   = TX_ACK;
          end else begin
            key_cnt_d = key_cnt_q + 4'd1;
          end
        end
`ifdef MACGUFFIN_FRAME_CTRL_TIMEOUT_EN
        else if (gap_expired) begin
          gap_d   = '0;
          state_d = TX_NAK;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
`endif
      end
      CIPH_REQ: begin
        if (c_m_axis_tready) state_d = CIPH_WAIT;
      end
      CIPH_WAIT: begin
        if (c_s_axis_tvalid) begin
          res_d      = c_s_axis_tdata;
          byte_cnt_d = '0;
          state_d    = TX_DATA;
        end
      end
      TX_DATA: begin
        if (m_axis_tready) begin
          res_d = {res_q[55:0], 8'h00};
          if (byte_cnt_q == 3'd7) begin
            byte_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      TX_ACK, TX_NAK: begin
        if (m_axis_tready) state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame and restores the initial key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      stage_q    <= '0;
      key_q      <= INIT_KEY;
      commit_q   <= 1'b0;
      res_q      <= '0;
      byte_cnt_q <= '0;
      key_cnt_q  <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      stage_q    <= stage_d;
      key_q      <= key_d;
      commit_q   <= commit_d;
      res_q      <= res_d;
      byte_cnt_q <= byte_cnt_d;
      key_cnt_q  <= key_cnt_d;
      rdy_en_q   <= 1'b1;
    end
  end

`ifdef MACGUFFIN_FRAME_CTRL_TIMEOUT_EN
  // Idle-gap counter for the receive states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`endif

endmodule

// File: tb/tb_macguffin_frame_ctrl.sv
// tb/tb_macguffin_frame_ctrl.sv - directed and randomized checks of macguffin_frame_ctrl against a frame-level model
module tb_macguffin_frame_ctrl;
  localparam logic [127:0] INIT_KEY = 128'h1748a65f73b56f5eafecc84639475860;
  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [7:0]   m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic [63:0]  c_m_axis_tdata;
  logic         c_m_axis_tvalid;
  logic         c_m_axis_tready = 1'b0;
  logic [63:0]  c_s_axis_tdata = '0;
  logic         c_s_axis_tvalid = 1'b0;
  logic         c_s_axis_tready;
  logic [127:0] key;
  logic         busy;

  always #5 clk = ~clk;

  macguffin_frame_ctrl #(.INIT_KEY(INIT_KEY), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tvalid(c_m_axis_tvalid), .c_m_axis_tready(c_m_axis_tready),
    .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tvalid(c_s_axis_tvalid), .c_s_axis_tready(c_s_axis_tready),
    .key(key), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level model
  logic [7:0]   frame_q[$];
  logic [7:0]   exp_out[$];
  logic [63:0]  exp_blk[$];
  logic [127:0] exp_key = INIT_KEY;
  bit           responding = 0;
  bit           waiting = 0;
  bit           ready_en = 0;
  logic [63:0]  resp = '0;
  int           gap = 0;
  logic [7:0]   out_log[$];
  logic [63:0]  blk_log[$];

  // Stimulus controls
  int           m_mode = 0;
  int           stall_cnt = 0;
  bit           cs_hold = 0;
  logic [7:0]   tx[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic logic [63:0] cipher(input logic [63:0] b, input logic [127:0] k);
    return ~b ^ (k[127:64] ^ k[63:0]) ^ (INIT_KEY[127:64] ^ INIT_KEY[63:0]);
  endfunction

  task automatic model_reset();
    frame_q.delete();
    exp_out.delete();
    exp_blk.delete();
    exp_key    = INIT_KEY;
    responding = 0;
    waiting    = 0;
    ready_en   = 0;
    gap        = 0;
  endtask

  task automatic accept_byte(input logic [7:0] b);
    frame_q.push_back(b);
    gap = 0;
    if (frame_q[0] == 8'h45) begin
      if (frame_q.size() == 9) begin
        logic [63:0] blk;
        blk = '0;
        for (int i = 1; i < 9; i++) blk[8*(8-i) +: 8] = frame_q[i];
        exp_blk.push_back(blk);
        frame_q.delete();
        responding = 1;
      end
    end else if (frame_q[0] == 8'h4B) begin
      if (frame_q.size() == 17) begin
        logic [127:0] k;
        k = '0;
        for (int i = 1; i < 17; i++) k[8*(16-i) +: 8] = frame_q[i];
        exp_key = k;
        exp_out.push_back(8'h06);
        frame_q.delete();
        responding = 1;
      end
    end else begin
      exp_out.push_back(8'h15);
      frame_q.delete();
      responding = 1;
    end
  endtask

  // Compare every cycle against the model, then advance the model by this cycle's handshakes
  always @(negedge clk) begin : cmp_blk
    bit s_hs, m_hs, cm_hs, cs_hs, mbusy;
    if (!rst_n) begin
      check("rst s_tready", s_axis_tready, 0);
      check("rst m_tvalid", m_axis_tvalid, 0);
      check("rst cm_tvalid", c_m_axis_tvalid, 0);
      check("rst cs_tready", c_s_axis_tready, 0);
      check("rst busy", busy, 0);
      check("rst key", key, INIT_KEY);
      check("rst m_tdata", m_axis_tdata, 0);
      check("rst cm_tdata", c_m_axis_tdata, 0);
      model_reset();
    end else begin
      mbusy = responding || (frame_q.size() != 0);
      check("s_tready", s_axis_tready, ready_en && !responding);
      check("busy", busy, mbusy);
      check("m_tvalid", m_axis_tvalid, exp_out.size() != 0);
      if (exp_out.size() != 0) check("m_tdata", m_axis_tdata, exp_out[0]);
      check("cm_tvalid", c_m_axis_tvalid, exp_blk.size() != 0);
      if (exp_blk.size() != 0) check("cm_tdata", c_m_axis_tdata, exp_blk[0]);
      check("cs_tready", c_s_axis_tready, waiting);
      if (!mbusy) check("key", key, exp_key);

      s_hs  = s_axis_tvalid && ready_en && !responding;
      m_hs  = m_axis_tready && (exp_out.size() != 0);
      cm_hs = c_m_axis_tready && (exp_blk.size() != 0);
      cs_hs = c_s_axis_tvalid && waiting;

      if (m_hs) begin
        out_log.push_back(exp_out.pop_front());
        if (exp_out.size() == 0) responding = 0;
      end
      if (cm_hs) begin
        blk_log.push_back(exp_blk[0]);
        resp    = cipher(exp_blk.pop_front(), exp_key);
        waiting = 1;
      end
      if (cs_hs) begin
        for (int i = 7; i >= 0; i--) exp_out.push_back(resp[8*i +: 8]);
        waiting = 0;
      end
      if (s_hs) accept_byte(s_axis_tdata);
`ifdef MACGUFFIN_FRAME_CTRL_TIMEOUT_EN
      else if (frame_q.size() != 0) begin
        if (gap == TO - 1) begin
          frame_q.delete();
          exp_out.push_back(8'h15);
          responding = 1;
          gap = 0;
        end else begin
          gap++;
        end
      end
`endif
      ready_en = 1;
    end
  end

  // UART sink ready: random, or a 50-cycle stall on the fourth data byte
  initial forever begin
    @(posedge clk); #1;
    if (m_mode == 1) begin
      if (exp_out.size() == 5 && stall_cnt < 50) begin
        m_axis_tready = 1'b0;
        stall_cnt++;
      end else begin
        m_axis_tready = 1'b1;
      end
    end else begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Cipher core: random ready/valid, garbage offered outside the wait window
  initial forever begin
    @(posedge clk); #1;
    c_m_axis_tready = $urandom_range(0, 1) != 0;
    if (cs_hold) begin
      c_s_axis_tvalid = 1'b0;
    end else if (waiting) begin
      c_s_axis_tvalid = $urandom_range(0, 1) != 0;
      c_s_axis_tdata  = resp;
    end else begin
      c_s_axis_tvalid = $urandom_range(0, 1) != 0;
      c_s_axis_tdata  = {$urandom, $urandom};
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int budget;
    if ($urandom_range(0, 3) == 0) begin
      s_axis_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    budget = 0;
    forever begin
      @(negedge clk);
      if (rst_n && s_axis_tready) break;
      budget++;
      if (budget > 3000) begin bound_fail("s_handshake"); break; end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (tx[i]) send_byte(tx[i]);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    forever begin
      @(negedge clk);
      if (!responding && !waiting && frame_q.size() == 0 && exp_out.size() == 0 && exp_blk.size() == 0) break;
      budget++;
      if (budget > 3000) begin bound_fail("wait_idle"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_random_frame();
    int kind;
    logic [7:0] b;
    kind = $urandom_range(0, 2);
    tx.delete();
    if (kind == 0) begin
      tx.push_back(8'h45);
      repeat (8) tx.push_back(8'($urandom));
    end else if (kind == 1) begin
      tx.push_back(8'h4B);
      repeat (16) tx.push_back(8'($urandom));
    end else begin
      do b = 8'($urandom); while (b == 8'h45 || b == 8'h4B);
      tx.push_back(b);
    end
    send_frame();
  endtask

  initial begin : watchdog
    #900000;
    bound_fail("global watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : main
    logic [7:0] e023 [8];
    int budget;
    e023 = '{8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Encrypt frame with a fixed block under the initial key
    out_log.delete(); blk_log.delete();
    tx = '{8'h45, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    send_frame();
    wait_idle();
    check("T023 nblk", blk_log.size(), 1);
    if (blk_log.size() != 0) check("T023 block", blk_log[0], 64'h0123456789ABCDEF);
    check("T023 nbytes", out_log.size(), 8);
    for (int i = 0; i < out_log.size() && i < 8; i++) check("T023 byte", out_log[i], e023[i]);

    // Key load 00..0F, then an encrypt frame under the new key
    out_log.delete();
    tx.delete(); tx.push_back(8'h4B);
    for (int i = 0; i < 16; i++) tx.push_back(8'(i));
    send_frame();
    wait_idle();
    check("T024 key", key, 128'h000102030405060708090A0B0C0D0E0F);
    check("T024 nbytes", out_log.size(), 1);
    if (out_log.size() != 0) check("T024 ack", out_log[0], 8'h06);
    out_log.delete();
    tx = '{8'h45, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    send_frame();
    wait_idle();
    check("T024 enc nbytes", out_log.size(), 8);

    // Unknown command byte
    out_log.delete();
    tx = '{8'h99};
    send_frame();
    wait_idle();
    check("T025 nbytes", out_log.size(), 1);
    if (out_log.size() != 0) check("T025 nak", out_log[0], 8'h15);
    check("T025 key", key, 128'h000102030405060708090A0B0C0D0E0F);
    @(negedge clk);
    check("T025 busy", busy, 0);
    @(posedge clk); #1;

    // Output stall mid-response with the next frame already pending
    out_log.delete();
    m_mode = 1; stall_cnt = 0;
    tx.delete(); tx.push_back(8'h45);
    repeat (8) tx.push_back(8'($urandom));
    send_frame();
    tx = '{8'h99};
    send_frame();
    wait_idle();
    check("T027 stall", stall_cnt, 50);
    check("T027 nbytes", out_log.size(), 9);
    if (out_log.size() == 9) check("T027 nak", out_log[8], 8'h15);
    m_mode = 0;

    // Partial key frame followed by a long idle gap
    do_reset();
    out_log.delete();
    tx = '{8'h4B, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_frame();
    repeat (110) @(posedge clk);
`ifdef MACGUFFIN_FRAME_CTRL_TIMEOUT_EN
    wait_idle();
    check("T026 nbytes", out_log.size(), 1);
    if (out_log.size() != 0) check("T026 nak", out_log[0], 8'h15);
    check("T026 key", key, INIT_KEY);
`else
    @(negedge clk);
    check("T026 nbytes", out_log.size(), 0);
    check("T026 busy", busy, 1);
    check("T026 key", key, INIT_KEY);
`endif
    do_reset();

    // Reset while waiting on the cipher, after a key load
    tx.delete(); tx.push_back(8'h4B);
    repeat (16) tx.push_back(8'($urandom));
    send_frame();
    wait_idle();
    cs_hold = 1;
    tx.delete(); tx.push_back(8'h45);
    repeat (8) tx.push_back(8'($urandom));
    send_frame();
    budget = 0;
    while (!waiting && budget < 3000) begin @(negedge clk); budget++; end
    if (!waiting) bound_fail("T028 cipher wait");
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("T028 m_tvalid", m_axis_tvalid, 0);
    check("T028 cm_tvalid", c_m_axis_tvalid, 0);
    check("T028 key", key, INIT_KEY);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cs_hold = 0;
    out_log.delete();
    tx.delete(); tx.push_back(8'h45);
    repeat (8) tx.push_back(8'($urandom));
    send_frame();
    wait_idle();
    check("T028 next nbytes", out_log.size(), 8);

    // Randomized frame mix, sometimes back to back
    for (int n = 0; n < 40; n++) begin
      send_random_frame();
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/macguffin_frame_ctrl.md
MACGUFFIN_FRAME_CTRL -- requirements
Module: macguffin_frame_ctrl

Interface
REQ-001 SHALL have parameter INIT_KEY, default 128'h1748a65f73b56f5eafecc84639475860, key value after reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 868_000, maximum idle gap between bytes inside a frame, in clk cycles.
REQ-003 SHALL have ports, one per line:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- s_axis_tdata/tvalid/tready  in/in/out  8/1/1  byte stream from UART.
- m_axis_tdata/tvalid/tready  out/out/in  8/1/1  byte stream to UART.
- c_m_axis_tdata/tvalid/tready  out/out/in  64/1/1  block to cipher.
- c_s_axis_tdata/tvalid/tready  in/in/out  64/1/1  block from cipher.
- key  output  128  cipher key.
- busy  output  1  high in any state except IDLE.

Function
REQ-004 SHALL implement FSM states IDLE, RX_KEY, RX_BLK, CIPH_REQ, CIPH_WAIT, TX_DATA, TX_ACK, TX_NAK.
REQ-005 SHALL drive s_axis_tready high only in IDLE, RX_KEY and RX_BLK.
REQ-006 In IDLE, an accepted byte 0x45 SHALL go to RX_BLK, 0x4B to RX_KEY, and any other byte to TX_NAK.
REQ-007 RX_BLK SHALL accept 8 bytes into a 64-bit shift register, first byte landing in [63:56], then go to CIPH_REQ.
REQ-008 RX_KEY SHALL accept 16 bytes into a 128-bit staging register, first byte in [127:120], then copy it to key in one cycle and go to TX_ACK.
REQ-009 key SHALL change only at REQ-008 completion; it is never partially updated.
REQ-010 CIPH_REQ SHALL assert c_m_axis_tvalid the cycle after the last byte is accepted, with tdata = block, and hold both stable until c_m_axis_tready; then go to CIPH_WAIT.
REQ-011 c_s_axis_tready SHALL be high only in CIPH_WAIT; c_s_axis_tvalid in any other state is ignored.
REQ-012 On the c_s_axis handshake, the FSM SHALL latch tdata and enter TX_DATA; m_axis_tvalid SHALL rise the next cycle.
REQ-013 TX_DATA SHALL send 8 bytes, [63:56] first, and advance only on m_axis_tvalid and m_axis_tready; tdata is stable while stalled. After the 8th byte it returns to IDLE.
REQ-014 TX_ACK SHALL send one byte 0x06; TX_NAK SHALL send one byte 0x15; each returns to IDLE after the handshake.
REQ-015 A 3-bit byte counter (RX_BLK/TX_DATA) and a 4-bit counter (RX_KEY) SHALL clear on state entry and never wrap within a frame.
REQ-016 Timeout: in RX_KEY or RX_BLK, a gap counter clears on each accepted byte and on state entry; on reaching TIMEOUT_CYCLES-1 with no byte, the partial frame SHALL be discarded (key unchanged) and the FSM goes to TX_NAK.
REQ-017 If a byte is accepted in the same cycle the timeout expires, the byte SHALL win and the counter clears.
REQ-018 No new frame SHALL be accepted until the current response is fully transmitted (s_axis_tready low).

Reset
REQ-019 While rst_n is low, the block SHALL hold: state IDLE, key = INIT_KEY, all counters 0, m_axis_tvalid = 0, c_m_axis_tvalid = 0, c_s_axis_tready = 0, s_axis_tready = 0, busy = 0, data outputs 0.
REQ-020 s_axis_tready SHALL go high on the first clk edge after rst_n deasserts.
REQ-021 Reset mid-frame or mid-cipher SHALL abandon the frame with no output byte, and key reverts to INIT_KEY.

Configuration
REQ-022 Macro MACGUFFIN_FRAME_CTRL_TIMEOUT_EN: when defined, REQ-016/017 apply; when undefined, the gap counter and its logic are absent and RX states wait indefinitely, with all other behaviour identical.

Verification
REQ-023 Send 0x45 then 01 23 45 67 89 AB CD EF -> c_m_axis_tdata=64'h0123456789ABCDEF one cycle after the last byte; cipher model returns 64'hFEDCBA9876543210 -> output bytes FE DC BA 98 76 54 32 10.
REQ-024 Send 0x4B plus 16 bytes 00..0F -> key=128'h000102030405060708090A0B0C0D0E0F, output 0x06; then an encrypt frame uses the new key.
REQ-025 Send byte 0x99 -> output 0x15; state IDLE; key unchanged.
REQ-026 With TIMEOUT_CYCLES=100 and the macro defined, send 0x4B plus 5 bytes then idle 100 cycles -> output 0x15, key still INIT_KEY; with the macro undefined -> no output and busy stays 1.
REQ-027 Hold m_axis_tready low 50 cycles during TX_DATA byte 3 -> tdata stable, no byte lost or duplicated, s_axis_tready=0 throughout.
REQ-028 Assert rst_n low during CIPH_WAIT after a key load -> all valids 0, key=INIT_KEY; next frame processes normally.
